// File: rtl/motor_ramp_sequencer.sv
// Enable sequencing and slew-rate limiting of signed left/right speed commands for two
// motor drivers, with settle time after enable, ramped stop and immediate e-stop.
//
// state  | meaning
// IDLE   | drivers disabled, commanded speeds held at zero
// ENABLE | drivers enabled at zero speed, counting settle ticks
// RUN    | ramping both motors toward the latched targets
// STOP   | ramping both motors toward zero, then back to IDLE
module motor_ramp_sequencer #(
    parameter int SPEED_W      = 10,
    parameter int TICK_DIV     = 100000,
    parameter int STEP         = 4,
    parameter int SETTLE_TICKS = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      run_en,
    input  logic                      estop,
    input  logic                      target_valid,
    input  logic signed [SPEED_W-1:0] target_left,
    input  logic signed [SPEED_W-1:0] target_right,
    output logic        [SPEED_W-1:0] speed_left,
    output logic                      dir_left,
    output logic        [SPEED_W-1:0] speed_right,
    output logic                      dir_right,
    output logic                      driver_en_n,
    output logic                      at_target,
    output logic        [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENABLE = 2'd1,
        RUN    = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SET_W = $clog2(SETTLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_TICKS - 1);
    localparam logic signed [SPEED_W-1:0] NEG_MIN = {1'b1, {(SPEED_W-1){1'b0}}};
    localparam logic signed [SPEED_W-1:0] NEG_LIM = {1'b1, {(SPEED_W-2){1'b0}}, 1'b1};
    localparam logic signed [SPEED_W:0]   STEP_X  = (SPEED_W+1)'(STEP);

    state_t                      state_q, state_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic        [SET_W-1:0]     settle_q, settle_d;
    logic signed [SPEED_W-1:0]   tgt_l_q, tgt_l_d;
    logic signed [SPEED_W-1:0]   tgt_r_q, tgt_r_d;
    logic signed [SPEED_W-1:0]   cur_l_q, cur_l_d;
    logic signed [SPEED_W-1:0]   cur_r_q, cur_r_d;
    logic                        tick;

    // The most negative code has no positive counterpart, so it is pulled in by one.
    function automatic logic signed [SPEED_W-1:0] clamp_tgt(input logic signed [SPEED_W-1:0] v);
        return (v == NEG_MIN) ? NEG_LIM : v;
    endfunction

    // One slew step toward goal; a step that would cross zero lands on zero instead.
    function automatic logic signed [SPEED_W-1:0] ramp_step(
        input logic signed [SPEED_W-1:0] cur,
        input logic signed [SPEED_W-1:0] goal
    );
        logic signed [SPEED_W:0] cur_x, diff, mag, nxt;
        cur_x = {cur[SPEED_W-1], cur};
        diff  = {goal[SPEED_W-1], goal} - cur_x;
        mag   = diff[SPEED_W] ? -diff : diff;
        if (mag > STEP_X) begin
            mag = STEP_X;
        end
        nxt = diff[SPEED_W] ? (cur_x - mag) : (cur_x + mag);
        if ((cur != '0) && (nxt != '0) && (nxt[SPEED_W] != cur[SPEED_W-1])) begin
            nxt = '0;
        end
        return nxt[SPEED_W-1:0];
    endfunction

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (estop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_en) state_d = ENABLE;
                end
                ENABLE: begin
                    if (!run_en)                          state_d = IDLE;
                    else if (tick && settle_q == SET_LAST) state_d = RUN;
                end
                RUN: begin
                    if (!run_en) state_d = STOP;
                end
                STOP: begin
                    if (run_en)                               state_d = RUN;
                    else if (cur_l_q == '0 && cur_r_q == '0)  state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        state       = state_q;
        driver_en_n = (state_q == IDLE);
        at_target   = (state_q == RUN) && (cur_l_q == tgt_l_q) && (cur_r_q == tgt_r_q);
        speed_left  = cur_l_q[SPEED_W-1] ? (~cur_l_q + SPEED_W'(1)) : cur_l_q;
        speed_right = cur_r_q[SPEED_W-1] ? (~cur_r_q + SPEED_W'(1)) : cur_r_q;
        dir_left    = ~cur_l_q[SPEED_W-1];
        dir_right   = ~cur_r_q[SPEED_W-1];
    end

    always_comb begin
        cnt_d    = tick ? '0 : (cnt_q + CNT_W'(1));
        tgt_l_d  = target_valid ? clamp_tgt(target_left)  : tgt_l_q;
        tgt_r_d  = target_valid ? clamp_tgt(target_right) : tgt_r_q;
        settle_d = '0;
        cur_l_d  = cur_l_q;
        cur_r_d  = cur_r_q;
        if (estop) begin
            cur_l_d = '0;
            cur_r_d = '0;
        end else begin
            case (state_q)
                ENABLE: begin
                    cur_l_d  = '0;
                    cur_r_d  = '0;
                    settle_d = (run_en && tick) ? (settle_q + SET_W'(1)) : settle_q;
                end
                RUN: begin
                    if (tick) begin
                        cur_l_d = ramp_step(cur_l_q, tgt_l_q);
                        cur_r_d = ramp_step(cur_r_q, tgt_r_q);
                    end
                end
                STOP: begin
                    if (tick) begin
                        cur_l_d = ramp_step(cur_l_q, '0);
                        cur_r_d = ramp_step(cur_r_q, '0);
                    end
                end
                default: begin
                    cur_l_d = '0;
                    cur_r_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            settle_q <= '0;
            tgt_l_q  <= '0;
            tgt_r_q  <= '0;
            cur_l_q  <= '0;
            cur_r_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            tgt_l_q  <= tgt_l_d;
            tgt_r_q  <= tgt_r_d;
            cur_l_q  <= cur_l_d;
            cur_r_q  <= cur_r_d;
        end
    end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: settle, ramp, reversal, e-stop, ramped stop, clamp.
module tb_motor_ramp_sequencer;

    localparam int SPEED_W      = 10;
    localparam int TICK_DIV     = 4;
    localparam int STEP         = 4;
    localparam int SETTLE_TICKS = 2;

    logic                      clock;
    logic                      reset;
    logic                      run_en;
    logic                      estop;
    logic                      target_valid;
    logic signed [SPEED_W-1:0] target_left;
    logic signed [SPEED_W-1:0] target_right;
    logic        [SPEED_W-1:0] speed_left;
    logic                      dir_left;
    logic        [SPEED_W-1:0] speed_right;
    logic                      dir_right;
    logic                      driver_en_n;
    logic                      at_target;
    logic        [1:0]         state;

    int checks = 0;
    int errors = 0;
    int tb_cnt;
    logic [25:0] exp_v;

    motor_ramp_sequencer #(
        .SPEED_W      (SPEED_W),
        .TICK_DIV     (TICK_DIV),
        .STEP         (STEP),
        .SETTLE_TICKS (SETTLE_TICKS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .run_en       (run_en),
        .estop        (estop),
        .target_valid (target_valid),
        .target_left  (target_left),
        .target_right (target_right),
        .speed_left   (speed_left),
        .dir_left     (dir_left),
        .speed_right  (speed_right),
        .dir_right    (dir_right),
        .driver_en_n  (driver_en_n),
        .at_target    (at_target),
        .state        (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side copy of the tick period, used only to know when a tick edge is due.
    always @(posedge clock or posedge reset) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
    end

    wire [25:0] obs = {state, driver_en_n, at_target, dir_left, speed_left, dir_right, speed_right};

    // Expected observation from state, enable, at_target and signed commanded speeds.
    function automatic logic [25:0] pack(input int st, input int en_n, input int at,
                                         input int cl, input int cr);
        logic [9:0] sl, sr;
        logic       dl, dr;
        sl = 10'(cl < 0 ? -cl : cl);
        sr = 10'(cr < 0 ? -cr : cr);
        dl = (cl >= 0);
        dr = (cr >= 0);
        return {st[1:0], en_n[0], at[0], dl, sl, dr, sr};
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_edge();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (tb_cnt != TICK_DIV - 1 && n < 20);
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: waited %0d cycles, limit 20", n);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_target(input logic signed [SPEED_W-1:0] l, input logic signed [SPEED_W-1:0] r);
        target_left  = l;
        target_right = r;
        target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run_en = 1'b0;
        estop = 1'b0;
        target_valid = 1'b0;
        target_left = '0;
        target_right = '0;
        repeat (2) cycle();
        exp_v = pack(0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_ramp_up();
        int exp_l [5] = '{0, 0, 4, 8, 10};
        int exp_s [5] = '{1, 2, 2, 2, 2};
        int exp_a [5] = '{0, 0, 0, 0, 1};
        set_target(10'sd10, 10'sd0);
        run_en = 1'b1;
        cycle();
        exp_v = pack(1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL enable_entry: got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            tick_edge();
            exp_v = pack(exp_s[i], 0, exp_a[i], exp_l[i], 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL ramp_up_tick%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reversal();
        int exp_l [5] = '{6, 2, 0, -4, -6};
        int exp_a [5] = '{1, 0, 0, 0, 1};
        set_target(10'sd6, 10'sd0);
        tick_edge();
        exp_v = pack(2, 0, exp_a[0], exp_l[0], 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reversal_pre: got %h expected %h", obs, exp_v);
        end
        set_target(-10'sd6, 10'sd0);
        for (int i = 1; i < 5; i++) begin
            tick_edge();
            exp_v = pack(2, 0, exp_a[i], exp_l[i], 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reversal_tick%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_estop();
        int exp_l [4] = '{-2, 0, 4, 8};
        set_target(10'sd10, 10'sd0);
        for (int i = 0; i < 4; i++) begin
            tick_edge();
            exp_v = pack(2, 0, 0, exp_l[i], 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL estop_ramp_tick%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        estop = 1'b1;
        cycle();
        exp_v = pack(0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL estop_entry: got %h expected %h", obs, exp_v);
        end
        repeat (6) cycle();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL estop_hold: got %h expected %h", obs, exp_v);
        end
        estop = 1'b0;
        cycle();
        exp_v = pack(1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL estop_release: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_stop();
        int up_l [5] = '{0, 0, 4, 8, 10};
        int up_s [5] = '{1, 2, 2, 2, 2};
        int up_a [5] = '{0, 0, 0, 0, 1};
        int dn_l [3] = '{6, 2, 0};
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                run_en = 1'b1;
                cycle();
            end
            for (int i = 0; i < 5; i++) begin
                tick_edge();
                exp_v = pack(up_s[i], 0, up_a[i], up_l[i], 0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL stop_up_p%0d_t%0d: got %h expected %h", pass, i, obs, exp_v);
                end
            end
            run_en = 1'b0;
            cycle();
            exp_v = pack(3, 0, 0, 10, 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stop_entry_p%0d: got %h expected %h", pass, obs, exp_v);
            end
            for (int i = 0; i < 3 - 2 * pass; i++) begin
                tick_edge();
                exp_v = pack(3, 0, 0, dn_l[i], 0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL stop_down_p%0d_t%0d: got %h expected %h", pass, i, obs, exp_v);
                end
            end
            if (pass == 0) begin
                cycle();
                exp_v = pack(0, 1, 0, 0, 0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL stop_to_idle: got %h expected %h", obs, exp_v);
                end
            end
        end
        run_en = 1'b1;
        cycle();
        exp_v = pack(2, 0, 0, 6, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rerun_no_settle: got %h expected %h", obs, exp_v);
        end
        tick_edge();
        exp_v = pack(2, 0, 1, 10, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rerun_target: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_clamp();
        int exp_l [5] = '{6, 2, 0, -4, -8};
        int exp_r [5] = '{4, 8, 12, 16, 20};
        logic signed [SPEED_W-1:0] most_neg;
        most_neg = 10'h200;
        set_target(most_neg, 10'sd20);
        for (int i = 0; i < 5; i++) begin
            tick_edge();
            exp_v = pack(2, 0, 0, exp_l[i], exp_r[i]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clamp_tick%0d: got %h expected %h", i + 1, obs, exp_v);
            end
        end
        repeat (125) tick_edge();
        exp_v = pack(2, 0, 0, -508, 20);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL clamp_tick130: got %h expected %h", obs, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            tick_edge();
            exp_v = pack(2, 0, 1, -511, 20);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clamp_final%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        set_target(10'sd0, 10'sd0);
        tick_edge();
        exp_v = pack(2, 0, 0, -507, 16);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_ramp: got %h expected %h", obs, exp_v);
        end
        #2 reset = 1'b1;
        #1;
        exp_v = pack(0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs, exp_v);
        end
        cycle();
        reset = 1'b0;
        cycle();
        exp_v = pack(1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL post_reset_enable: got %h expected %h", obs, exp_v);
        end
        repeat (2) tick_edge();
        exp_v = pack(2, 0, 1, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL targets_cleared: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reversal();
        test_estop();
        test_stop();
        test_clamp();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

endmodule
